// File: rtl/cmd_cfg_ext.sv
// Command decoder for the flight controller: setpoints, battery read, calibration and landing.
// Build with CMD_WDOG_EN defined to add the command watchdog that forces a landing.
module cmd_cfg_ext #(
  parameter int unsigned THRST_W   = 9,
  parameter int unsigned CAL_TMR_W = 9,
  parameter int unsigned WDOG_W    = 10,
  parameter int unsigned RAMP_STEP = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_rdy,
  input  logic [7:0]         cmd,
  input  logic [15:0]        data,
  input  logic [7:0]         batt,
  input  logic               cnv_cmplt,
  input  logic               cal_done,
  output logic               clr_cmd_rdy,
  output logic [7:0]         resp,
  output logic               send_resp,
  output logic [15:0]        d_ptch,
  output logic [15:0]        d_roll,
  output logic [15:0]        d_yaw,
  output logic [THRST_W-1:0] thrst,
  output logic               strt_cal,
  output logic               inertial_cal,
  output logic               motors_off,
  output logic               strt_cnv,
  output logic               wdog_trip
);

  localparam logic [7:0]         RespAck  = 8'hA5;
  localparam logic [7:0]         RespErr  = 8'hEE;
  localparam int unsigned        ThrstMax = (1 << THRST_W) - 1;
  localparam logic [THRST_W-1:0] Step     = THRST_W'(RAMP_STEP);

  if (THRST_W < 8 || THRST_W > 12 || CAL_TMR_W < 2 || WDOG_W < 2 || RAMP_STEP == 0)
  begin : g_param_chk
    $error("cmd_cfg_ext: parameter out of range");
  end

  typedef enum logic [2:0] {StIdle, StAck, StBatt, StCal1, StCal2, StLand} state_e;

  state_e               state_q, state_d;
  logic [15:0]          ptch_d, roll_d, yaw_d;
  logic [THRST_W-1:0]   thrst_d;
  logic                 moff_d;
  logic                 ack_err_q, ack_err_d;
  logic                 land_cmd_q, land_cmd_d;
  logic [CAL_TMR_W-1:0] cal_cnt_q, cal_cnt_d;
  logic                 consume;
`ifdef CMD_WDOG_EN
  logic [WDOG_W-1:0]    wdog_cnt_q, wdog_cnt_d;
  logic                 wdog_trip_q, wdog_trip_d;
`endif

  assign consume = (state_q == StIdle) && cmd_rdy;

  always_comb begin
    state_d      = state_q;
    ptch_d       = d_ptch;
    roll_d       = d_roll;
    yaw_d        = d_yaw;
    thrst_d      = thrst;
    moff_d       = motors_off;
    ack_err_d    = ack_err_q;
    land_cmd_d   = land_cmd_q;
    cal_cnt_d    = cal_cnt_q;
    clr_cmd_rdy  = 1'b0;
    resp         = 8'h00;
    send_resp    = 1'b0;
    strt_cal     = 1'b0;
    inertial_cal = 1'b0;
    strt_cnv     = 1'b0;
`ifdef CMD_WDOG_EN
    wdog_cnt_d   = wdog_cnt_q;
    wdog_trip_d  = wdog_trip_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (consume) begin
          clr_cmd_rdy = 1'b1;
          ack_err_d   = 1'b0;
          state_d     = StAck;
          case (cmd)
            8'h01: begin
              strt_cnv = 1'b1;
              state_d  = StBatt;
            end
            8'h02: ptch_d = data;
            8'h03: roll_d = data;
            8'h04: yaw_d  = data;
            8'h05: thrst_d = (32'(data) > ThrstMax) ? THRST_W'(ThrstMax) : data[THRST_W-1:0];
            8'h06: begin
              moff_d    = 1'b0;
              cal_cnt_d = '0;
              state_d   = StCal1;
            end
            8'h07: moff_d = 1'b1;
            8'h08: begin
              ptch_d     = 16'h0000;
              roll_d     = 16'h0000;
              yaw_d      = 16'h0000;
              land_cmd_d = 1'b1;
              state_d    = StLand;
            end
            default: ack_err_d = 1'b1;
          endcase
        end
      end
      StAck: begin
        send_resp = 1'b1;
        resp      = ack_err_q ? RespErr : RespAck;
        state_d   = StIdle;
      end
      StBatt: begin
        if (cnv_cmplt) begin
          send_resp = 1'b1;
          resp      = batt;
          state_d   = StIdle;
        end
      end
      StCal1: begin
        inertial_cal = 1'b1;
        if (&cal_cnt_q) begin
          strt_cal = 1'b1;
          state_d  = StCal2;
        end else begin
          cal_cnt_d = cal_cnt_q + 1'b1;
        end
      end
      StCal2: begin
        inertial_cal = 1'b1;
        if (cal_done) begin
          send_resp = 1'b1;
          resp      = RespAck;
          state_d   = StIdle;
        end
      end
      StLand: begin
        if (thrst == '0) begin
          send_resp = land_cmd_q;
          resp      = land_cmd_q ? RespAck : 8'h00;
          state_d   = StIdle;
        end else begin
          thrst_d = (thrst > Step) ? thrst - Step : '0;
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef CMD_WDOG_EN
    if (consume) begin
      wdog_cnt_d  = '0;
      wdog_trip_d = 1'b0;
    end else if (state_q == StIdle && !motors_off) begin
      if (&wdog_cnt_q) begin
        // Silent landing: no response, counter restarts so IDLE does not re-trip at once
        ptch_d      = 16'h0000;
        roll_d      = 16'h0000;
        yaw_d       = 16'h0000;
        wdog_trip_d = 1'b1;
        land_cmd_d  = 1'b0;
        wdog_cnt_d  = '0;
        state_d     = StLand;
      end else begin
        wdog_cnt_d = wdog_cnt_q + 1'b1;
      end
    end
`endif
    // A reset cycle must never leak a strobe from the state being aborted
    if (!rst_n) begin
      clr_cmd_rdy  = 1'b0;
      resp         = 8'h00;
      send_resp    = 1'b0;
      strt_cal     = 1'b0;
      inertial_cal = 1'b0;
      strt_cnv     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      d_ptch     <= 16'h0000;
      d_roll     <= 16'h0000;
      d_yaw      <= 16'h0000;
      thrst      <= '0;
      motors_off <= 1'b1;
      ack_err_q  <= 1'b0;
      land_cmd_q <= 1'b0;
      cal_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      d_ptch     <= ptch_d;
      d_roll     <= roll_d;
      d_yaw      <= yaw_d;
      thrst      <= thrst_d;
      motors_off <= moff_d;
      ack_err_q  <= ack_err_d;
      land_cmd_q <= land_cmd_d;
      cal_cnt_q  <= cal_cnt_d;
    end
  end

`ifdef CMD_WDOG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_cnt_q  <= '0;
      wdog_trip_q <= 1'b0;
    end else begin
      wdog_cnt_q  <= wdog_cnt_d;
      wdog_trip_q <= wdog_trip_d;
    end
  end

  assign wdog_trip = wdog_trip_q;
`else
  assign wdog_trip = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_cfg_ext.sv
// Self-checking bench for cmd_cfg_ext: vector table, directed corner sequences and a
// randomized command stream checked against a transaction-level model.
module tb_cmd_cfg_ext;

  localparam int THRST_W   = 9;
  localparam int CAL_TMR_W = 9;
  localparam int WDOG_W    = 10;
  localparam int RAMP_STEP = 4;
  localparam int THRST_MAX = (1 << THRST_W) - 1;

  logic               clk, rst_n, cmd_rdy, cnv_cmplt, cal_done;
  logic [7:0]         cmd, batt, resp;
  logic [15:0]        data, d_ptch, d_roll, d_yaw;
  logic [THRST_W-1:0] thrst;
  logic               clr_cmd_rdy, send_resp, strt_cal, inertial_cal, motors_off, strt_cnv;
  logic               wdog_trip;

  cmd_cfg_ext #(
    .THRST_W  (THRST_W),
    .CAL_TMR_W(CAL_TMR_W),
    .WDOG_W   (WDOG_W),
    .RAMP_STEP(RAMP_STEP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_rdy     (cmd_rdy),
    .cmd         (cmd),
    .data        (data),
    .batt        (batt),
    .cnv_cmplt   (cnv_cmplt),
    .cal_done    (cal_done),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .d_ptch      (d_ptch),
    .d_roll      (d_roll),
    .d_yaw       (d_yaw),
    .thrst       (thrst),
    .strt_cal    (strt_cal),
    .inertial_cal(inertial_cal),
    .motors_off  (motors_off),
    .strt_cnv    (strt_cnv),
    .wdog_trip   (wdog_trip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] data;
    logic [7:0]  resp;
    logic [15:0] ptch, roll, yaw, thrst;
    logic        moff;
  } vec_t;

  vec_t        tbl[11];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_ptch, m_roll, m_yaw;
  int          m_thrst;
  logic        m_moff, m_trip;
  int          land_exp[4] = '{10, 6, 2, 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One clock cycle with the strobe outputs checked at the falling edge.
  task automatic cyc(input string nm, input logic e_clr, input logic e_send,
                     input logic [7:0] e_resp, input logic e_cnv, input logic e_scal,
                     input logic e_ical);
    @(negedge clk);
    chk(nm, {19'd0, clr_cmd_rdy, send_resp, resp, strt_cnv, strt_cal, inertial_cal},
        {19'd0, e_clr, e_send, e_resp, e_cnv, e_scal, e_ical});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string nm);
    chk({nm, "_ptch"}, 32'(d_ptch), 32'(m_ptch));
    chk({nm, "_roll"}, 32'(d_roll), 32'(m_roll));
    chk({nm, "_yaw"}, 32'(d_yaw), 32'(m_yaw));
    chk({nm, "_thrst"}, 32'(thrst), 32'(m_thrst));
    chk({nm, "_moff"}, 32'(motors_off), 32'(m_moff));
    chk({nm, "_trip"}, 32'(wdog_trip), 32'(m_trip));
  endtask

  task automatic quiet();
    cmd_rdy = 1'b0; cmd = 8'h00; data = 16'h0000; batt = 8'h00;
    cnv_cmplt = 1'b0; cal_done = 1'b0;
  endtask

  task automatic noise();
    cmd_rdy = 1'($urandom); cmd = 8'($urandom); data = 16'($urandom);
    batt = 8'($urandom); cnv_cmplt = 1'($urandom); cal_done = 1'($urandom);
  endtask

  task automatic simple_txn(input string nm, input logic [7:0] c, input logic [15:0] d,
                            input logic [7:0] exp_resp);
    noise();
    cmd_rdy = 1'b1; cmd = c; data = d;
    cyc({nm, "_dec"}, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    noise();
    cyc({nm, "_ack"}, 1'b0, 1'b1, exp_resp, 1'b0, 1'b0, 1'b0);
    quiet();
  endtask

  task automatic rand_txn();
    logic [7:0]  c;
    logic [15:0] d;
    logic [7:0]  b;
    int          t;
    int          sel;
    sel = $urandom_range(0, 8);
    case (sel)
      0: c = 8'h01;
      1: c = 8'h02;
      2: c = 8'h03;
      3: c = 8'h04;
      4: c = 8'h05;
      5: c = 8'h07;
      6: c = 8'h08;
      default: begin
        c = 8'($urandom);
        if (c >= 8'h01 && c <= 8'h08) c = 8'h5A;
      end
    endcase
    d = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 600));
    if (c == 8'h01) begin
      noise(); cmd_rdy = 1'b1; cmd = c; data = d;
      cyc("rnd_batt_dec", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      repeat ($urandom_range(0, 5)) begin
        noise(); cnv_cmplt = 1'b0;
        cyc("rnd_batt_wait", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      end
      noise(); cnv_cmplt = 1'b1; b = 8'($urandom); batt = b;
      cyc("rnd_batt_resp", 1'b0, 1'b1, b, 1'b0, 1'b0, 1'b0);
    end else if (c == 8'h08) begin
      noise(); cmd_rdy = 1'b1; cmd = c; data = d;
      cyc("rnd_land_dec", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      m_ptch = 16'h0000; m_roll = 16'h0000; m_yaw = 16'h0000;
      t = m_thrst;
      while (t != 0) begin
        noise();
        chk("rnd_land_thrst", 32'(thrst), 32'(t));
        cyc("rnd_land_step", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        t = (t > RAMP_STEP) ? t - RAMP_STEP : 0;
      end
      noise();
      chk("rnd_land_zero", 32'(thrst), 32'd0);
      cyc("rnd_land_resp", 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      m_thrst = 0;
    end else begin
      case (c)
        8'h02: m_ptch = d;
        8'h03: m_roll = d;
        8'h04: m_yaw = d;
        8'h05: m_thrst = (int'(d) > THRST_MAX) ? THRST_MAX : int'(d);
        8'h07: m_moff = 1'b1;
        default: ;
      endcase
      simple_txn("rnd", c, d, (sel >= 7) ? 8'hEE : 8'hA5);
    end
    quiet();
    m_trip = 1'b0;
    chk_regs("rnd");
    repeat ($urandom_range(0, 2)) cyc("rnd_gap", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int found;
    int bad;

    tbl[0]  = '{8'h02, 16'h1234, 8'hA5, 16'h1234, 16'h0000, 16'h0000, 16'h000, 1'b1};
    tbl[1]  = '{8'h05, 16'h0300, 8'hA5, 16'h1234, 16'h0000, 16'h0000, 16'h1FF, 1'b1};
    tbl[2]  = '{8'h03, 16'hBEEF, 8'hA5, 16'h1234, 16'hBEEF, 16'h0000, 16'h1FF, 1'b1};
    tbl[3]  = '{8'h04, 16'h8001, 8'hA5, 16'h1234, 16'hBEEF, 16'h8001, 16'h1FF, 1'b1};
    tbl[4]  = '{8'h05, 16'h01FF, 8'hA5, 16'h1234, 16'hBEEF, 16'h8001, 16'h1FF, 1'b1};
    tbl[5]  = '{8'h05, 16'h0200, 8'hA5, 16'h1234, 16'hBEEF, 16'h8001, 16'h1FF, 1'b1};
    tbl[6]  = '{8'h05, 16'h0007, 8'hA5, 16'h1234, 16'hBEEF, 16'h8001, 16'h007, 1'b1};
    tbl[7]  = '{8'h3C, 16'h9999, 8'hEE, 16'h1234, 16'hBEEF, 16'h8001, 16'h007, 1'b1};
    tbl[8]  = '{8'h07, 16'h0000, 8'hA5, 16'h1234, 16'hBEEF, 16'h8001, 16'h007, 1'b1};
    tbl[9]  = '{8'h00, 16'hFFFF, 8'hEE, 16'h1234, 16'hBEEF, 16'h8001, 16'h007, 1'b1};
    tbl[10] = '{8'h05, 16'h000A, 8'hA5, 16'h1234, 16'hBEEF, 16'h8001, 16'h00A, 1'b1};

    // Reset: strobes held low even with requests pending, registers at reset values
    rst_n = 1'b0;
    quiet();
    cmd_rdy = 1'b1; cmd = 8'h02; cnv_cmplt = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cyc("reset_strobes", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    m_ptch = 16'h0000; m_roll = 16'h0000; m_yaw = 16'h0000;
    m_thrst = 0; m_moff = 1'b1; m_trip = 1'b0;
    chk_regs("reset");
    quiet();
    rst_n = 1'b1;
    cyc("idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 11; i++) begin
      simple_txn($sformatf("tbl%0d", i), tbl[i].cmd, tbl[i].data, tbl[i].resp);
      m_ptch = tbl[i].ptch; m_roll = tbl[i].roll; m_yaw = tbl[i].yaw;
      m_thrst = int'(tbl[i].thrst); m_moff = tbl[i].moff;
      chk_regs($sformatf("tbl%0d", i));
    end

    // Landing ramp from 0x0A with step 4
    cmd_rdy = 1'b1; cmd = 8'h08; data = 16'hFFFF;
    cyc("land_dec", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    quiet();
    chk("land_angles", {d_ptch, d_roll | d_yaw}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("land_thrst%0d", i), 32'(thrst), 32'(land_exp[i]));
      cyc("land_step", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    chk("land_thrst3", 32'(thrst), 32'(land_exp[3]));
    cyc("land_resp", 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    cyc("land_idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    m_ptch = 16'h0000; m_roll = 16'h0000; m_yaw = 16'h0000; m_thrst = 0;
    chk_regs("land");

    // Battery read; a command raised with cnv_cmplt waits for IDLE
    cmd_rdy = 1'b1; cmd = 8'h01; data = 16'hFFFF;
    cyc("batt_dec", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    quiet();
    for (int i = 0; i < 10; i++) cyc("batt_wait", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cnv_cmplt = 1'b1; batt = 8'hC3; cmd_rdy = 1'b1; cmd = 8'h02; data = 16'h2222;
    cyc("batt_resp", 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    cnv_cmplt = 1'b0;
    cyc("batt_pend_dec", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    quiet();
    cyc("batt_pend_ack", 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    m_ptch = 16'h2222;
    chk_regs("batt");

    // Calibration: spin-up wait, strt_cal pulse, then wait for cal_done
    cmd_rdy = 1'b1; cmd = 8'h06;
    cyc("cal_dec", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    quiet();
    n = 0; found = 0; bad = 0;
    for (int i = 0; i < 4 * (1 << CAL_TMR_W); i++) begin
      @(negedge clk);
      if (strt_cal) begin
        found = 1;
        break;
      end
      if (!inertial_cal || send_resp || clr_cmd_rdy) bad = 1;
      n++;
      @(posedge clk);
      #1;
      noise();
    end
    chk("cal_strt_seen", 32'(found), 32'd1);
    chk("cal_wait_cycles", 32'(n), 32'((1 << CAL_TMR_W) - 1));
    chk("cal1_window", 32'(bad), 32'd0);
    chk("cal_strt_ical", {31'd0, inertial_cal}, 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      noise(); cal_done = 1'b0;
      cyc("cal2_wait", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    end
    noise(); cal_done = 1'b1;
    cyc("cal_resp", 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
    quiet();
    m_moff = 1'b0;
    chk_regs("cal");
    simple_txn("bad_op", 8'h3C, 16'h1111, 8'hEE);
    chk_regs("bad_op");

    // Long silence with motors running
    simple_txn("wd_thr", 8'h05, 16'h0020, 8'hA5);
    simple_txn("wd_ptch", 8'h02, 16'h5555, 8'hA5);
    m_thrst = 32; m_ptch = 16'h5555;
`ifdef CMD_WDOG_EN
    n = 0; found = 0; bad = 0;
    for (int i = 0; i < (1 << WDOG_W) + 100; i++) begin
      @(negedge clk);
      if (wdog_trip) begin
        found = 1;
        break;
      end
      if (send_resp) bad = 1;
      n++;
      @(posedge clk);
      #1;
    end
    chk("wdog_seen", 32'(found), 32'd1);
    chk("wdog_idle_cycles", 32'(n), 32'(1 << WDOG_W));
    @(posedge clk);
    #1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (send_resp) bad = 1;
      @(posedge clk);
      #1;
    end
    chk("wdog_silent", 32'(bad), 32'd0);
    m_ptch = 16'h0000; m_roll = 16'h0000; m_yaw = 16'h0000; m_thrst = 0; m_trip = 1'b1;
    chk_regs("wdog_land");
    simple_txn("wdog_clr", 8'h03, 16'h0F0F, 8'hA5);
    m_roll = 16'h0F0F; m_trip = 1'b0;
    chk_regs("wdog_clr");
`else
    bad = 0;
    for (int i = 0; i < (1 << WDOG_W) + 100; i++) begin
      @(negedge clk);
      if (send_resp || wdog_trip) bad = 1;
      @(posedge clk);
      #1;
    end
    chk("nowdog_quiet", 32'(bad), 32'd0);
    chk_regs("nowdog");
`endif

    for (int i = 0; i < 150; i++) rand_txn();

    // Reset while waiting for a conversion must drop the pending response
    cmd_rdy = 1'b1; cmd = 8'h01;
    cyc("abort_dec", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    quiet();
    cyc("abort_wait", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0; cnv_cmplt = 1'b1; batt = 8'h77; cmd_rdy = 1'b1;
    cyc("abort_rst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    quiet();
    m_ptch = 16'h0000; m_roll = 16'h0000; m_yaw = 16'h0000;
    m_thrst = 0; m_moff = 1'b1; m_trip = 1'b0;
    chk_regs("abort");
    cnv_cmplt = 1'b1;
    cyc("abort_after0", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc("abort_after1", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
